// File: rtl/mul_pkg.sv
// Shared constants, FSM encoding and helpers for the multiplier arbiter.
// Imported by the interface, the round-robin picker and the top level.
package mul_pkg;

  localparam int NUM_REQ         = 4;
  localparam int GRANT_W         = 2;
  localparam int OP_W            = 32;
  localparam int RES_W           = 64;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [GRANT_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals of the arbiter.
// slave = the arbiter itself, master = requesters plus the shared multiplier.
interface mul_arbiter_if;
  import mul_pkg::*;

  // Handshake: a requester raises req[i] as a level with its operands stable and
  // keeps it until ack[i] pulses for one cycle (operands latched at that point).
  // rsp_valid is a one-cycle strobe with no backpressure; rsp_id/rsp_err/rsp_result
  // are meaningful only while it is high. m_op_start/m_op_clear are one-cycle
  // strobes to the multiplier; m_op_done is only observed while waiting.
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*OP_W-1:0] opa;
  logic [NUM_REQ*OP_W-1:0] opb;
  logic [NUM_REQ-1:0]      ack;
  logic                    rsp_valid;
  logic [GRANT_W-1:0]      rsp_id;
  logic [RES_W-1:0]        rsp_result;
  logic                    rsp_err;
  logic                    busy;
  logic [OP_W-1:0]         m_multiplier;
  logic [OP_W-1:0]         m_multiplicand;
  logic                    m_op_start;
  logic                    m_op_clear;
  logic                    m_op_done;
  logic [RES_W-1:0]        m_result;
  logic                    m_reset_n;

  modport slave (
    input  req, opa, opb, m_op_done, m_result,
    output ack, rsp_valid, rsp_id, rsp_result, rsp_err, busy,
           m_multiplier, m_multiplicand, m_op_start, m_op_clear, m_reset_n
  );

  modport master (
    output req, opa, opb, m_op_done, m_result,
    input  ack, rsp_valid, rsp_id, rsp_result, rsp_err, busy,
           m_multiplier, m_multiplicand, m_op_start, m_op_clear, m_reset_n
  );

endinterface

// File: rtl/mul_arbiter_rr_arb4.sv
// Combinational 4-way round-robin pick: lowest-index active request at or
// above (last_grant+1), wrapping around.
module rr_arb4
  import mul_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               gnt_valid,
  output logic [GRANT_W-1:0] gnt_idx
);

  logic [GRANT_W-1:0]   start_idx;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [GRANT_W-1:0]   offset;

  always_comb begin
    start_idx = last_grant + 2'd1;
    req_dbl   = {req, req};
    // Rotating the doubled vector puts the highest-priority requester at bit 0.
    req_rot   = req_dbl[start_idx +: NUM_REQ];
    offset    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = GRANT_W'(i);
    end
    gnt_valid = |req;
    gnt_idx   = start_idx + offset;
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one external multiplier among four requesters,
// with a WAIT-state timeout that returns an error response.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  mul_arbiter_if.slave bus,
  output state_t       dbg_state
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [GRANT_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [GRANT_W-1:0]  rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic                m_op_start_q, m_op_start_d;
  logic                m_op_clear_q, m_op_clear_d;
  logic [OP_W-1:0]     m_multiplier_q, m_multiplier_d;
  logic [OP_W-1:0]     m_multiplicand_q, m_multiplicand_d;

  logic                gnt_valid;
  logic [GRANT_W-1:0]  gnt_idx;

  rr_arb4 u_rr_arb4 (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    cnt_d            = cnt_q;
    ack_d            = '0;
    rsp_valid_d      = 1'b0;
    rsp_id_d         = rsp_id_q;
    rsp_result_d     = rsp_result_q;
    rsp_err_d        = 1'b0;
    m_op_start_d     = 1'b0;
    m_op_clear_d     = 1'b0;
    m_multiplier_d   = m_multiplier_q;
    m_multiplicand_d = m_multiplicand_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          last_grant_d     = gnt_idx;
          m_multiplier_d   = bus.opa[{gnt_idx, 5'd0} +: OP_W];
          m_multiplicand_d = bus.opb[{gnt_idx, 5'd0} +: OP_W];
          ack_d            = idx_to_onehot(gnt_idx);
          m_op_start_d     = 1'b1;
          state_d          = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Done is tested first so it wins over a timeout in the same cycle.
        if (bus.m_op_done) begin
          rsp_result_d = bus.m_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = last_grant_q;
          m_op_clear_d = 1'b1;
          state_d      = CLEAR;
        end else if (cnt_q == CNT_LAST) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = last_grant_q;
          m_op_clear_d = 1'b1;
          state_d      = CLEAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      last_grant_q     <= 2'd3;
      cnt_q            <= '0;
      ack_q            <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_id_q         <= '0;
      rsp_result_q     <= '0;
      rsp_err_q        <= 1'b0;
      busy_q           <= 1'b0;
      m_op_start_q     <= 1'b0;
      m_op_clear_q     <= 1'b0;
      m_multiplier_q   <= '0;
      m_multiplicand_q <= '0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      cnt_q            <= cnt_d;
      ack_q            <= ack_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_id_q         <= rsp_id_d;
      rsp_result_q     <= rsp_result_d;
      rsp_err_q        <= rsp_err_d;
      busy_q           <= busy_d;
      m_op_start_q     <= m_op_start_d;
      m_op_clear_q     <= m_op_clear_d;
      m_multiplier_q   <= m_multiplier_d;
      m_multiplicand_q <= m_multiplicand_d;
    end
  end

  assign bus.ack            = ack_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_id         = rsp_id_q;
  assign bus.rsp_result     = rsp_result_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.busy           = busy_q;
  assign bus.m_multiplier   = m_multiplier_q;
  assign bus.m_multiplicand = m_multiplicand_q;
  assign bus.m_op_start     = m_op_start_q;
  assign bus.m_op_clear     = m_op_clear_q;
  // The multiplier restarts together with the arbiter.
  assign bus.m_reset_n      = ~reset;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed plus randomized bench for mul_arbiter, with a behavioural multiplier
// and a round-robin reference model that tracks the set of pending requesters.
module tb_mul_arbiter;
  import mul_pkg::*;

  localparam int TO = 64;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;

  mul_arbiter_if bus ();

  mul_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference-model state
  int          last_exp = 3;
  logic [3:0]  pending  = 4'b0000;
  logic [31:0] opa_a [4];
  logic [31:0] opb_a [4];

  // Behavioural multiplier
  bit          mul_stuck     = 1'b0;
  bit          spurious_done = 1'b0;
  int          mul_cnt       = 0;
  logic [63:0] mul_prod      = '0;
  bit          mul_done_drv;

  always @(negedge clk) begin
    mul_done_drv = 1'b0;
    if (reset) begin
      mul_cnt = 0;
    end else if (bus.m_op_start) begin
      mul_cnt  = $urandom_range(1, 6);
      mul_prod = 64'(bus.m_multiplier) * 64'(bus.m_multiplicand);
    end else if (mul_cnt != 0) begin
      mul_cnt = mul_cnt - 1;
      if (mul_cnt == 0 && !mul_stuck) mul_done_drv = 1'b1;
    end
    bus.m_op_done = mul_done_drv | spurious_done;
    bus.m_result  = mul_prod;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_expect(input logic [3:0] pend, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pick_op();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 32'h0;
    if (sel == 1) return 32'hFFFF_FFFF;
    return $urandom();
  endfunction

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    opa_a[i] = a;
    opb_a[i] = b;
    bus.opa[32*i +: 32] = a;
    bus.opb[32*i +: 32] = b;
  endtask

  task automatic wait_ack(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.ack != 4'b0000) begin
        seen = 1'b1;
        break;
      end
    end
    check("ack_seen", 64'(seen), 64'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ack"},        64'(bus.ack),            64'd0);
    check({pfx, "_rsp_valid"},  64'(bus.rsp_valid),      64'd0);
    check({pfx, "_rsp_err"},    64'(bus.rsp_err),        64'd0);
    check({pfx, "_rsp_id"},     64'(bus.rsp_id),         64'd0);
    check({pfx, "_rsp_result"}, bus.rsp_result,          64'd0);
    check({pfx, "_busy"},       64'(bus.busy),           64'd0);
    check({pfx, "_start"},      64'(bus.m_op_start),     64'd0);
    check({pfx, "_clear"},      64'(bus.m_op_clear),     64'd0);
    check({pfx, "_mplier"},     64'(bus.m_multiplier),   64'd0);
    check({pfx, "_mcand"},      64'(bus.m_multiplicand), 64'd0);
    check({pfx, "_state"},      64'(dbg_state),          64'(IDLE));
    check({pfx, "_reset_n"},    64'(bus.m_reset_n),      64'd0);
  endtask

  // Serves the next request the model predicts and checks grant and response.
  task automatic serve_one(output int id, output logic [63:0] res);
    int          exp_id;
    logic [63:0] exp_prod;
    bit          seen;
    id     = -1;
    res    = '0;
    exp_id = rr_expect(pending, last_exp);
    wait_ack(seen);
    if (!seen) begin
      pending = '0;
      bus.req = '0;
      return;
    end
    check("ack_grant", 64'(bus.ack), 64'd1 << exp_id);
    check("op_start", 64'(bus.m_op_start), 64'd1);
    check("busy_start", 64'(bus.busy), 64'd1);
    check("mplier", 64'(bus.m_multiplier), 64'(opa_a[exp_id]));
    check("mcand", 64'(bus.m_multiplicand), 64'(opb_a[exp_id]));
    exp_prod        = 64'(opa_a[exp_id]) * 64'(opb_a[exp_id]);
    bus.req[exp_id] = 1'b0;
    pending[exp_id] = 1'b0;
    last_exp        = exp_id;
    // Operands changing after the grant must not reach the operation in flight.
    set_ops(exp_id, pick_op(), pick_op());
    seen = 1'b0;
    for (int n = 0; n < TO + 10; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("ack_pulse", 64'(bus.ack), 64'd0);
        check("start_pulse", 64'(bus.m_op_start), 64'd0);
      end
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("rsp_seen", 64'(seen), 64'd1);
    if (!seen) return;
    check("rsp_id", 64'(bus.rsp_id), 64'(exp_id));
    check("rsp_result", bus.rsp_result, exp_prod);
    check("rsp_err", 64'(bus.rsp_err), 64'd0);
    check("op_clear", 64'(bus.m_op_clear), 64'd1);
    id  = exp_id;
    res = bus.rsp_result;
  endtask

  initial begin
    int          id;
    int          prev;
    int          n_wait;
    int          rsp_cnt;
    logic [63:0] res;
    logic [3:0]  mask;
    bit          seen;

    // Reset
    reset   = 1'b1;
    bus.req = '0;
    bus.opa = '0;
    bus.opb = '0;
    for (int i = 0; i < 4; i++) set_ops(i, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("reset_n_high", 64'(bus.m_reset_n), 64'd1);
    check("idle_after_rst", 64'(dbg_state), 64'(IDLE));

    // Single request
    set_ops(0, 32'h17, 32'h568);
    bus.req = 4'b0001;
    pending = 4'b0001;
    serve_one(id, res);
    check("single_id", 64'(id), 64'd0);
    check("single_prod", res, 64'h7C58);

    // All four after reset: order 0,1,2,3
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    last_exp = 3;
    for (int i = 0; i < 4; i++) set_ops(i, 32'(i + 1), 32'd3);
    bus.req = 4'b1111;
    pending = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      serve_one(id, res);
      check("all4_id", 64'(id), 64'(k));
      check("all4_prod", res, 64'(3 * (k + 1)));
    end

    // Fairness: 0 and 2 keep requesting
    prev = -1;
    set_ops(0, pick_op(), pick_op());
    set_ops(2, pick_op(), pick_op());
    bus.req = 4'b0101;
    pending = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      serve_one(id, res);
      check("fair_id", 64'(id), (k % 2 == 0) ? 64'd0 : 64'd2);
      check("fair_no_repeat", 64'(id == prev), 64'd0);
      prev = id;
      if (k < 3 && id >= 0) begin
        set_ops(id, pick_op(), pick_op());
        bus.req[id] = 1'b1;
        pending[id] = 1'b1;
      end
    end
    while (pending != 4'b0000) serve_one(id, res);

    // Randomized traffic with late arrivals
    for (int it = 0; it < 25; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) if (mask[i]) set_ops(i, pick_op(), pick_op());
      bus.req = bus.req | mask;
      pending = pending | mask;
      for (int s = 0; s < 10 && pending != 4'b0000; s++) begin
        serve_one(id, res);
        if ($urandom_range(0, 2) == 0) begin
          mask = 4'($urandom_range(0, 15)) & ~pending;
          for (int i = 0; i < 4; i++) if (mask[i]) set_ops(i, pick_op(), pick_op());
          bus.req = bus.req | mask;
          pending = pending | mask;
        end
      end
      while (pending != 4'b0000) serve_one(id, res);
    end

    // Timeout with a multiplier that never completes
    repeat (2) @(negedge clk);
    mul_stuck = 1'b1;
    set_ops(2, 32'h1234, 32'h5678);
    bus.req = 4'b0100;
    wait_ack(seen);
    check("to_ack", 64'(bus.ack), 64'h4);
    bus.req  = 4'b0000;
    last_exp = 2;
    n_wait   = 0;
    for (int n = 1; n <= 3 * TO; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        n_wait = n;
        break;
      end
    end
    check("to_cycles", 64'(n_wait), 64'(TO + 1));
    check("to_err", 64'(bus.rsp_err), 64'd1);
    check("to_result", bus.rsp_result, 64'd0);
    check("to_id", 64'(bus.rsp_id), 64'd2);
    mul_stuck = 1'b0;
    set_ops(3, 32'hDEAD_BEEF, 32'h10);
    bus.req = 4'b1000;
    pending = 4'b1000;
    serve_one(id, res);
    check("after_to_id", 64'(id), 64'd3);

    // Reset during WAIT aborts with no response
    mul_stuck = 1'b1;
    set_ops(0, 32'h55, 32'h66);
    bus.req = 4'b0001;
    wait_ack(seen);
    bus.req = 4'b0000;
    repeat (5) @(negedge clk);
    check("mid_state_wait", 64'(dbg_state), 64'(WAIT));
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset     = 1'b0;
    last_exp  = 3;
    mul_stuck = 1'b0;
    rsp_cnt   = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_cnt++;
    end
    check("midrst_no_rsp", 64'(rsp_cnt), 64'd0);
    set_ops(1, 32'h7, 32'h9);
    bus.req = 4'b0010;
    pending = 4'b0010;
    serve_one(id, res);
    check("midrst_next_id", 64'(id), 64'd1);

    // Spurious multiplier done while idle
    repeat (2) @(negedge clk);
    spurious_done = 1'b1;
    rsp_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_cnt++;
      check("spur_state", 64'(dbg_state), 64'(IDLE));
      check("spur_busy", 64'(bus.busy), 64'd0);
    end
    spurious_done = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_no_rsp", 64'(rsp_cnt), 64'd0);
    set_ops(2, 32'h3, 32'h4);
    bus.req = 4'b0100;
    pending = 4'b0100;
    serve_one(id, res);
    check("spur_next_prod", res, 64'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
